inst_fetch_ctrl: RTL and testbench

Instruction-fetch requester for the stalling instruction memory. It drives the word address and chip select, and holds the address stable while the memory reports stall. It captures the returned word into a one-entry output register with a valid/ready handshake toward the decode stage. It handles PC sequencing, branch redirects mid-fetch, fetch enable, and a stall-timeout error.

---
 rtl/inst_fetch_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// inst_fetch_ctrl
//
// Instruction-fetch requester for a stalling instruction memory. It presents
// a word address with chip select, holds that address steady while the
// memory stalls, and captures the returned word into a single-entry output
// register that hands off to decode with a valid/ready handshake.
//
// It also handles PC sequencing, branch redirects in the middle of a fetch,
// fetch enable, and a sticky error when a request stalls for too long.
//
// Flow summary:
//   IDLE -> REQ   when fetch_en is high.
//   REQ  -> IDLE  when fetch_en drops; no capture happens in that cycle.
//   REQ  -> ERR   after TIMEOUT consecutive stalled request cycles.
//   ERR  -> REQ/IDLE only on a redirect (or on reset).
//   A redirect in any state reloads the PC and drops any buffered or
//   in-flight instruction.
// ---------------------------------------------------------------------------
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 64,
    parameter int unsigned CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,

    // Fetch control from the pipeline front end
    input  logic        fetch_en,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,

    // Instruction memory request side
    output logic [31:0] mem_addr,
    output logic        mem_cs,
    input  logic        mem_stall,
    input  logic [31:0] mem_data,

    // Decode-facing output slot
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,

    // Sticky stall-timeout error
    output logic        fetch_err
);

    // -----------------------------------------------------------------------
    // Types and constants
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    // Word-aligned PCs only: the two low bits are always cleared.
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC_AL   = RESET_PC & PC_ALIGN_MASK;

    // Stall counter value at which one more stalled cycle means a timeout.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    // -----------------------------------------------------------------------
    // State registers and their next-state values
    // -----------------------------------------------------------------------
    state_e           state_q,      state_d;
    logic [31:0]      pc_q,         pc_d;
    logic [CNT_W-1:0] wait_cnt_q,   wait_cnt_d;
    logic             inst_valid_q, inst_valid_d;
    logic [31:0]      inst_out_q,   inst_out_d;
    logic [31:0]      inst_pc_q,    inst_pc_d;
    logic             fetch_err_q,  fetch_err_d;
    logic             mem_cs_q,     mem_cs_d;

    // Handshake helpers for the one-entry output slot
    logic             slot_free;
    logic             consume;

    // Output slot can take a new word if it is empty or is being drained now.
    assign slot_free = !inst_valid_q || inst_ready;
    assign consume   = inst_valid_q && inst_ready;

    // -----------------------------------------------------------------------
    // Next-state logic: redirect overrides everything, otherwise per-state.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a hold value first; a path
        // that forgets one would otherwise infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        wait_cnt_d   = wait_cnt_q;
        inst_valid_d = inst_valid_q;
        inst_out_d   = inst_out_q;
        inst_pc_d    = inst_pc_q;
        fetch_err_d  = fetch_err_q;

        // Decode taking the buffered word empties the slot, unless a
        // capture below refills it in the same cycle (no bubble).
        if (consume) begin
            inst_valid_d = 1'b0;
        end

        if (redirect) begin
            // Jump to the new target; anything buffered or in flight is
            // from the wrong path and is thrown away. Also the only way out
            // of the error state short of reset.
            pc_d         = redirect_pc & PC_ALIGN_MASK;
            inst_valid_d = 1'b0;
            wait_cnt_d   = '0;
            fetch_err_d  = 1'b0;
            state_d      = fetch_en ? ST_REQ : ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    wait_cnt_d = '0;
                    if (fetch_en) begin
                        state_d = ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (!fetch_en) begin
                        // Stop requesting; PC is held so fetching resumes at
                        // the same word. A buffered word stays until taken.
                        state_d    = ST_IDLE;
                        wait_cnt_d = '0;
                    end else if (mem_stall) begin
                        if (wait_cnt_q == WAIT_LAST) begin
                            // Memory never answered: give up and flag it.
                            state_d      = ST_ERR;
                            fetch_err_d  = 1'b1;
                            inst_valid_d = 1'b0;
                            wait_cnt_d   = '0;
                        end else begin
                            wait_cnt_d = wait_cnt_q + 1'b1;
                        end
                    end else begin
                        wait_cnt_d = '0;
                        if (slot_free) begin
                            // Data is ready and there is room: take it and
                            // move to the next word (wraps at the top of
                            // the address space).
                            inst_out_d   = mem_data;
                            inst_pc_d    = pc_q;
                            inst_valid_d = 1'b1;
                            pc_d         = pc_q + 32'd4;
                        end
                        // Otherwise the slot is full: keep the same address
                        // presented and retry once decode drains the slot.
                    end
                end

                ST_ERR: begin
                    fetch_err_d = 1'b1;
                    wait_cnt_d  = '0;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Chip select is registered and simply mirrors "next state is REQ".
        mem_cs_d = (state_d == ST_REQ);
    end

    // -----------------------------------------------------------------------
    // State update with asynchronous active-high reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so all
        // registers update together from the values computed above.
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC_AL;
            wait_cnt_q   <= '0;
            inst_valid_q <= 1'b0;
            inst_out_q   <= '0;
            inst_pc_q    <= '0;
            fetch_err_q  <= 1'b0;
            mem_cs_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            wait_cnt_q   <= wait_cnt_d;
            inst_valid_q <= inst_valid_d;
            inst_out_q   <= inst_out_d;
            inst_pc_q    <= inst_pc_d;
            fetch_err_q  <= fetch_err_d;
            mem_cs_q     <= mem_cs_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Memory is word addressed: drop the byte offset of the PC.
    assign mem_addr   = {2'b00, pc_q[31:2]};
    assign mem_cs     = mem_cs_q;
    assign inst_valid = inst_valid_q;
    assign inst_out   = inst_out_q;
    assign inst_pc    = inst_pc_q;
    assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_ctrl
//
// Directed bench for inst_fetch_ctrl. A small memory model stalls for
// LAT cycles after every new (chip-select, address) presentation, and can be
// forced to stall forever. Memory word at address a is {16'hC0DE, a[15:0]}.
// ---------------------------------------------------------------------------
module tb_inst_fetch_ctrl;

    localparam int LAT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] mem_addr;
    logic        mem_cs;
    logic        mem_stall;
    logic [31:0] mem_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        fetch_err;

    int tests_run = 0;
    int tests_failed = 0;

    // Memory model state
    int          lat_cnt = 0;
    logic [31:0] seen_addr = '0;
    logic        seen_cs = 1'b0;
    logic        force_stall = 1'b0;

    inst_fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (64),
        .CNT_W    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_addr    (mem_addr),
        .mem_cs      (mem_cs),
        .mem_stall   (mem_stall),
        .mem_data    (mem_data),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_out    (inst_out),
        .inst_pc     (inst_pc),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    // Count how long the current presentation has been held; restart on any
    // address change or chip-select drop.
    always @(negedge clk) begin
        if (mem_cs && seen_cs && (mem_addr == seen_addr)) lat_cnt = lat_cnt + 1;
        else                                               lat_cnt = 0;
        seen_addr = mem_addr;
        seen_cs   = mem_cs;
    end

    assign mem_stall = force_stall | (mem_cs && (lat_cnt < LAT));
    assign mem_data  = {16'hC0DE, mem_addr[15:0]};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called in cycle 0 of a fresh fetch of exp_pc with an empty slot:
    // LAT stalled cycles with a stable address, then the capture.
    task automatic expect_fetch(input string tag, input logic [31:0] exp_pc);
        logic [31:0] nxt;
        nxt = exp_pc + 32'd4;
        for (int i = 0; i < LAT; i++) begin
            tick();
            check({tag, "_addr_hold"}, mem_addr, {2'b00, exp_pc[31:2]});
            check({tag, "_no_valid"}, {31'd0, inst_valid}, 32'd1 - 32'd1);
        end
        tick();
        check({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
        check({tag, "_data"}, inst_out, {16'hC0DE, exp_pc[17:2]});
        check({tag, "_pc"}, inst_pc, exp_pc);
        check({tag, "_next_addr"}, mem_addr, {2'b00, nxt[31:2]});
    endtask

    initial begin
        rst = 1'b1; fetch_en = 1'b1; redirect = 1'b0;
        redirect_pc = '0; inst_ready = 1'b0;

        // ---- Reset state --------------------------------------------------
        #2;
        check("rst_cs", {31'd0, mem_cs}, 32'd0);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_out", inst_out, 32'd0);
        check("rst_ipc", inst_pc, 32'd0);
        check("rst_err", {31'd0, fetch_err}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        tick(); tick();
        rst = 1'b0;

        // ---- First fetch after reset: IDLE then REQ -----------------------
        check("idle_cs", {31'd0, mem_cs}, 32'd0);
        tick();
        check("req_cs", {31'd0, mem_cs}, 32'd1);
        check("req_addr", mem_addr, 32'd0);
        expect_fetch("f0", 32'h0000_0000);

        // ---- Slot full: decode not ready ----------------------------------
        for (int i = 0; i < 12; i++) begin
            tick();
            check("full_addr", mem_addr, 32'd1);
            check("full_out", inst_out, 32'hC0DE_0000);
            check("full_valid", {31'd0, inst_valid}, 32'd1);
        end
        check("full_cs", {31'd0, mem_cs}, 32'd1);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("nobubble_valid", {31'd0, inst_valid}, 32'd1);
        check("nobubble_out", inst_out, 32'hC0DE_0001);
        check("nobubble_pc", inst_pc, 32'h0000_0004);
        check("nobubble_addr", mem_addr, 32'd2);

        // ---- Redirect mid-stall of word 2 ---------------------------------
        for (int i = 0; i < 5; i++) tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0023;
        tick();
        redirect = 1'b0;
        inst_ready = 1'b1;
        check("redir_addr", mem_addr, 32'd8);
        check("redir_valid", {31'd0, inst_valid}, 32'd0);
        check("redir_cs", {31'd0, mem_cs}, 32'd1);
        expect_fetch("f20", 32'h0000_0020);

        // ---- Redirect on a would-be capture -------------------------------
        for (int i = 0; i < LAT; i++) tick();
        check("pre_cap_valid", {31'd0, inst_valid}, 32'd0);
        redirect = 1'b1; redirect_pc = 32'h0000_0040;
        tick();
        redirect = 1'b0;
        check("cap_redir_valid", {31'd0, inst_valid}, 32'd0);
        check("cap_redir_addr", mem_addr, 32'h0000_0010);
        expect_fetch("f40", 32'h0000_0040);

        // ---- fetch_en low: idle, buffered word kept -----------------------
        inst_ready = 1'b0; fetch_en = 1'b0;
        tick();
        check("dis_cs", {31'd0, mem_cs}, 32'd0);
        check("dis_valid", {31'd0, inst_valid}, 32'd1);
        check("dis_ipc", inst_pc, 32'h0000_0040);
        tick();
        check("dis_addr", mem_addr, 32'h0000_0011);
        check("dis_cs2", {31'd0, mem_cs}, 32'd0);
        fetch_en = 1'b1; inst_ready = 1'b1;
        tick();
        check("en_cs", {31'd0, mem_cs}, 32'd1);
        check("en_consumed", {31'd0, inst_valid}, 32'd0);
        expect_fetch("f44", 32'h0000_0044);

        // ---- Stall timeout ------------------------------------------------
        force_stall = 1'b1;
        for (int i = 0; i < 63; i++) tick();
        check("to_before_err", {31'd0, fetch_err}, 32'd0);
        check("to_before_cs", {31'd0, mem_cs}, 32'd1);
        tick();
        check("to_err", {31'd0, fetch_err}, 32'd1);
        check("to_cs", {31'd0, mem_cs}, 32'd0);
        check("to_valid", {31'd0, inst_valid}, 32'd0);
        force_stall = 1'b0;
        tick(); tick(); tick();
        check("err_sticky", {31'd0, fetch_err}, 32'd1);
        check("err_cs", {31'd0, mem_cs}, 32'd0);
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        check("err_clr", {31'd0, fetch_err}, 32'd0);
        check("err_resume_cs", {31'd0, mem_cs}, 32'd1);
        check("err_resume_addr", mem_addr, 32'h0000_0040);
        expect_fetch("f100", 32'h0000_0100);

        // ---- PC wrap at the top of the address space ----------------------
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect = 1'b0;
        check("wrap_addr", mem_addr, 32'h3FFF_FFFF);
        expect_fetch("fwrap", 32'hFFFF_FFFC);

        // ---- Async reset mid-stall ----------------------------------------
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        check("arst_cs", {31'd0, mem_cs}, 32'd0);
        check("arst_valid", {31'd0, inst_valid}, 32'd0);
        check("arst_out", inst_out, 32'd0);
        check("arst_ipc", inst_pc, 32'd0);
        check("arst_addr", mem_addr, 32'd0);
        check("arst_err", {31'd0, fetch_err}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_cs", {31'd0, mem_cs}, 32'd1);
        expect_fetch("fpost", 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
